uart_tx_frame_ctrl: RTL

//  Parametrised UART transmit controller: next generation of the TX FSM. It absorbs the

---
 rtl/uart_tx_frame_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//   UART transmit controller with an integrated serializer, parity generator,
//   bit counter and baud prescaler. It accepts a DATA_WIDTH word and sends a
//   full frame on TX_OUT:
//     start bit, data bits LSB first, optional parity bit, 1 or 2 stop bits.
//   A new word offered in the last stop cycle is chained straight into the
//   next start bit, so no idle bit is inserted between the two frames.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   PRESCALE    clocks per bit period (>= 2)
//   CNT_WIDTH   bit index counter width, must hold DATA_WIDTH-1
//
// Ports
//   CLK            in  clock, rising edge
//   RST            in  synchronous reset, active-high
//   P_DATA         in  parallel word, latched on accept
//   Data_Valid     in  request to send P_DATA
//   parity_enable  in  1: append a parity bit (latched on accept)
//   parity_type    in  0: even, 1: odd (latched on accept)
//   two_stop       in  0: one stop bit, 1: two stop bits (latched on accept)
//   TX_OUT         out serial line, registered, idles high
//   Busy           out high from the first START cycle to the last STOP cycle
//   tx_done        out one-cycle pulse in the last cycle of the final stop bit
// ----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  two_stop,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  tx_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic                  stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  bit_end;
  logic                  accept;
  logic                  data_bit;
  logic                  last_stop_bit;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      idx_q      <= '0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    idx_d      = idx_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    accept     = 1'b0;

    bit_end = (pcnt_q == PW'(PRESCALE - 1));

    // Prescaler free-runs inside a frame and wraps at the end of each bit.
    if (state_q != IDLE) begin
      pcnt_d = bit_end ? '0 : pcnt_q + PW'(1);
    end

    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (Data_Valid) begin
          accept = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            stop2_d = 1'b0;
          end else begin
            idx_d = idx_q + CNT_WIDTH'(1);
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop2_d = 1'b0;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else if (Data_Valid) begin
            // Chain the next word straight into its start bit.
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d    = START;
      pcnt_d     = '0;
      idx_d      = '0;
      stop2_d    = 1'b0;
      data_d     = P_DATA;
      par_en_d   = parity_enable;
      par_odd_d  = parity_type;
      two_stop_d = two_stop;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are decoded from the next state and registered, so
  // they line up with the state the frame is in during the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    data_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (idx_d == CNT_WIDTH'(i)) begin
        data_bit = data_d[i];
      end
    end

    last_stop_bit = !two_stop_d || stop2_d;

    tx_d   = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;

    unique case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end
      START: begin
        tx_d = 1'b0;
      end
      DATA: begin
        tx_d = data_bit;
      end
      PARITY: begin
        tx_d = par_odd_d ? ~^data_d : ^data_d;
      end
      STOP: begin
        done_d = last_stop_bit && (pcnt_d == PW'(PRESCALE - 1));
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign TX_OUT  = tx_q;
  assign Busy    = busy_q;
  assign tx_done = done_q;

endmodule
